clock_set_ctrl: RTL and testbench
=================================

Name: clock_set_ctrl

Overview:
- Run/set controller for the six-digit BCD time-of-day counter (hour1..sec0).
- In RUN it generates the 1 Hz count-enable tick from the system clock.
- In SET it pauses counting and lets the user edit hours, minutes and seconds with two buttons, then loads the edited time into the counter.
- Sits between the debounced button logic and the time counter; its outputs also drive the display blink.

Parameters:
CLK_DIV, 50000000, system clock cycles per second tick (≥2)
REPEAT_DLY, 25000000, cycles btn_inc must be held before auto-repeat starts
REPEAT_PER, 5000000, cycles between auto-repeat increments
BLINK_DIV, 12500000, cycles per blink half-period

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
btn_mode  input  1  debounced, synchronous level; each rising edge advances mode
btn_inc  input  1  debounced, synchronous level; rising edge or auto-repeat increments the selected field
cur_hour1, cur_hour0, cur_min1, cur_min0, cur_sec1, cur_sec0  input  4 each  live BCD time from the counter
sec_tick  output  1  one-cycle count enable for the time counter, once per second in RUN only
load  output  1  one-cycle strobe; the counter loads the ld_* digits
ld_hour1, ld_hour0, ld_min1, ld_min0, ld_sec1, ld_sec0  output  4 each  shadow (edited) BCD time
mode  output  2  0=RUN, 1=SET_H, 2=SET_M, 3=SET_S
blink  output  1  display blink phase for the selected field; 0 in RUN

Behaviour:
- Reset (async, while rst_n=0): mode=RUN; sec_tick=0; load=0; blink=0; all ld_* = 0; prescaler, repeat and blink counters = 0; button history registers = 0.
- Edge detection: btn_*_q holds the previous-cycle level. A press is btn & ~btn_q. Presses are acted on at the same clock edge on which they are sampled.
- Prescaler:
  - Counts 0..CLK_DIV-1 in RUN. sec_tick=1 for one cycle when the count equals CLK_DIV-1, then the count wraps to 0.
  - Held at 0 in all SET states. sec_tick is never 1 outside RUN.
- FSM:
  - RUN + mode press -> SET_H. At that edge ld_* captures cur_* (snapshot).
  - SET_H -> SET_M -> SET_S on each mode press.
  - SET_S + mode press -> RUN. load is registered high for exactly the first cycle in RUN and carries the final ld_* values. The prescaler restarts from 0, so the first sec_tick follows load by CLK_DIV cycles.
- Abort: mode press and inc press on the same edge in any SET state -> RUN with no load and no increment. ld_* is left unchanged.
- In RUN:
  - Inc presses are ignored.
  - Mode and inc pressed together behave as a mode press only.
- Increment (SET states only), BCD with wrap:
  - SET_H: 00..23, 23 -> 00. Tens increment when units reach 9 (09 -> 10, 19 -> 20); 23 -> 00.
  - SET_M / SET_S: 00..59, 59 -> 00; x9 -> (x+1)0.
  - Only the selected field changes; other digits are held.
- Auto-repeat:
  - The repeat counter clears on any inc press, on btn_inc=0 and on every state change.
  - While btn_inc stays high in a SET state, one increment occurs when the hold count reaches REPEAT_DLY, then one every REPEAT_PER cycles after that.
  - Never more than one increment per cycle.
- Blink: in SET states blink toggles every BLINK_DIV cycles. It is forced to 1 on entering each SET state, and forced to 0 in RUN.
- Reset mid-SET: returns to RUN immediately with no load; ld_* = 0.
- Invalid snapshot digits (e.g. hour 27): the increment still wraps to 00 from any value ≥ the field maximum.

Test Plan (CLK_DIV=10, REPEAT_DLY=20, REPEAT_PER=5, BLINK_DIV=4):
- Reset, then hold btn_mode/btn_inc low for 35 cycles -> sec_tick pulses 1 cycle wide at cycles 10, 20, 30 after reset release; load stays 0, mode=0, blink=0.
- Live 23:59:58; press mode -> mode=1, ld_*=2,3,5,9,5,8, sec_tick stays 0. Press inc once -> ld_hour=00. Press mode three times -> load=1 for one cycle, ld=00:59:58, mode=0; next sec_tick exactly 10 cycles after load.
- SET_M from ld_min=58: three inc presses -> 59, 00, 01; hour and second digits unchanged.
- SET_S with ld_sec=00: hold btn_inc 40 cycles -> increments at press, hold count 20, 25, 30, 35 -> ld_sec=05; release -> no further change.
- SET_H: pulse btn_mode and btn_inc on the same cycle -> mode=0 next cycle, load never asserts, ld_* unchanged, sec_tick resumes after 10 cycles.
- In SET_M, drop rst_n mid-cycle -> outputs are at reset values asynchronously: mode=0, ld_*=0, blink=0, load=0.

Source files
------------

// File: rtl/clock_set_ctrl.sv
// rtl/clock_set_ctrl.sv - run/set controller for the six-digit BCD time-of-day counter
module clock_set_ctrl #(
    parameter int CLK_DIV    = 50000000,
    parameter int REPEAT_DLY = 25000000,
    parameter int REPEAT_PER = 5000000,
    parameter int BLINK_DIV  = 12500000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       btn_mode,
    input  logic       btn_inc,
    input  logic [3:0] cur_hour1,
    input  logic [3:0] cur_hour0,
    input  logic [3:0] cur_min1,
    input  logic [3:0] cur_min0,
    input  logic [3:0] cur_sec1,
    input  logic [3:0] cur_sec0,
    output logic       sec_tick,
    output logic       load,
    output logic [3:0] ld_hour1,
    output logic [3:0] ld_hour0,
    output logic [3:0] ld_min1,
    output logic [3:0] ld_min0,
    output logic [3:0] ld_sec1,
    output logic [3:0] ld_sec0,
    output logic [1:0] mode,
    output logic       blink
);

    localparam int PW   = $clog2(CLK_DIV);
    localparam int RMAX = (REPEAT_DLY > REPEAT_PER) ? REPEAT_DLY : REPEAT_PER;
    localparam int RW   = $clog2(RMAX + 1);
    localparam int BW   = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

    localparam logic [PW-1:0] PRESC_MAX = PW'(CLK_DIV - 1);
    localparam logic [BW-1:0] BLINK_MAX = BW'(BLINK_DIV - 1);
    localparam logic [RW-1:0] REP_DLY   = RW'(REPEAT_DLY);
    localparam logic [RW-1:0] REP_PER   = RW'(REPEAT_PER);

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        SET_H = 2'd1,
        SET_M = 2'd2,
        SET_S = 2'd3
    } state_t;

    state_t        state, state_nxt;
    logic          btn_mode_q, btn_inc_q;
    logic [PW-1:0] presc;
    logic [RW-1:0] rep_cnt;
    logic          rep_run;
    logic [BW-1:0] blink_cnt;

    logic          mode_press, inc_press;
    logic [RW-1:0] rep_nxt, rep_lim;
    logic          rep_hit;
    logic          snap, do_inc, do_load;

    // Values at or above the field maximum (including invalid snapshots) wrap to 00.
    function automatic logic [7:0] bcd_inc(input logic [3:0] t, input logic [3:0] u,
                                           input logic [7:0] max);
        logic [7:0] v;
        v = {4'd0, t} * 8'd10 + {4'd0, u};
        if (v >= max)
            return 8'h00;
        else if (u >= 4'd9)
            return {t + 4'd1, 4'd0};
        else
            return {t, u + 4'd1};
    endfunction

    assign mode_press = btn_mode & ~btn_mode_q;
    assign inc_press  = btn_inc & ~btn_inc_q;
    assign rep_nxt    = rep_cnt + 1'b1;
    assign rep_lim    = rep_run ? REP_PER : REP_DLY;
    assign rep_hit    = btn_inc && (rep_nxt == rep_lim);
    assign mode       = state;

    always_comb begin
        state_nxt = state;
        snap      = 1'b0;
        do_inc    = 1'b0;
        do_load   = 1'b0;
        unique case (state)
            RUN: begin
                if (mode_press) begin
                    state_nxt = SET_H;
                    snap      = 1'b1;
                end
            end
            SET_H, SET_M, SET_S: begin
                if (mode_press && inc_press) begin
                    state_nxt = RUN;
                end else if (mode_press) begin
                    unique case (state)
                        SET_H:   state_nxt = SET_M;
                        SET_M:   state_nxt = SET_S;
                        default: state_nxt = RUN;
                    endcase
                    do_load = (state == SET_S);
                end else if (inc_press || rep_hit) begin
                    do_inc = 1'b1;
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= RUN;
            btn_mode_q <= 1'b0;
            btn_inc_q  <= 1'b0;
            presc      <= '0;
            sec_tick   <= 1'b0;
            load       <= 1'b0;
            rep_cnt    <= '0;
            rep_run    <= 1'b0;
            blink_cnt  <= '0;
            blink      <= 1'b0;
        end else begin
            state      <= state_nxt;
            btn_mode_q <= btn_mode;
            btn_inc_q  <= btn_inc;
            load       <= do_load;

            // Tick only while staying in RUN so no tick ever lands in a SET cycle.
            sec_tick <= 1'b0;
            if (state == RUN && state_nxt == RUN) begin
                if (presc == PRESC_MAX) begin
                    presc    <= '0;
                    sec_tick <= 1'b1;
                end else begin
                    presc <= presc + 1'b1;
                end
            end else begin
                presc <= '0;
            end

            if (state == RUN || state_nxt != state || !btn_inc || inc_press) begin
                rep_cnt <= '0;
                rep_run <= 1'b0;
            end else if (rep_nxt == rep_lim) begin
                rep_cnt <= '0;
                rep_run <= 1'b1;
            end else begin
                rep_cnt <= rep_nxt;
            end

            if (state_nxt == RUN) begin
                blink     <= 1'b0;
                blink_cnt <= '0;
            end else if (state_nxt != state) begin
                blink     <= 1'b1;
                blink_cnt <= '0;
            end else if (blink_cnt == BLINK_MAX) begin
                blink     <= ~blink;
                blink_cnt <= '0;
            end else begin
                blink_cnt <= blink_cnt + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ld_hour1 <= 4'd0;
            ld_hour0 <= 4'd0;
            ld_min1  <= 4'd0;
            ld_min0  <= 4'd0;
            ld_sec1  <= 4'd0;
            ld_sec0  <= 4'd0;
        end else if (snap) begin
            ld_hour1 <= cur_hour1;
            ld_hour0 <= cur_hour0;
            ld_min1  <= cur_min1;
            ld_min0  <= cur_min0;
            ld_sec1  <= cur_sec1;
            ld_sec0  <= cur_sec0;
        end else if (do_inc) begin
            unique case (state)
                SET_H:   {ld_hour1, ld_hour0} <= bcd_inc(ld_hour1, ld_hour0, 8'd23);
                SET_M:   {ld_min1, ld_min0}   <= bcd_inc(ld_min1, ld_min0, 8'd59);
                SET_S:   {ld_sec1, ld_sec0}   <= bcd_inc(ld_sec1, ld_sec0, 8'd59);
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_clock_set_ctrl.sv
// tb/tb_clock_set_ctrl.sv - scoreboard bench for clock_set_ctrl against a time-value model
module tb_clock_set_ctrl;

    localparam int CLK_DIV    = 10;
    localparam int REPEAT_DLY = 20;
    localparam int REPEAT_PER = 5;
    localparam int BLINK_DIV  = 4;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       btn_mode = 1'b0;
    logic       btn_inc = 1'b0;
    logic [3:0] cur_d [6];
    logic       sec_tick, load, blink;
    logic [1:0] mode;
    logic [3:0] ld_hour1, ld_hour0, ld_min1, ld_min0, ld_sec1, ld_sec0;

    clock_set_ctrl #(
        .CLK_DIV(CLK_DIV), .REPEAT_DLY(REPEAT_DLY), .REPEAT_PER(REPEAT_PER), .BLINK_DIV(BLINK_DIV)
    ) dut (
        .clk(clk), .rst_n(rst_n), .btn_mode(btn_mode), .btn_inc(btn_inc),
        .cur_hour1(cur_d[0]), .cur_hour0(cur_d[1]), .cur_min1(cur_d[2]),
        .cur_min0(cur_d[3]), .cur_sec1(cur_d[4]), .cur_sec0(cur_d[5]),
        .sec_tick(sec_tick), .load(load),
        .ld_hour1(ld_hour1), .ld_hour0(ld_hour0), .ld_min1(ld_min1),
        .ld_min0(ld_min0), .ld_sec1(ld_sec1), .ld_sec0(ld_sec0),
        .mode(mode), .blink(blink)
    );

    always #5 clk = ~clk;

    int          n_checks = 0;
    int          n_fail = 0;
    bit          mon_en = 1'b0;
    logic [28:0] exp_q[$];

    // Model: mode number, edited digits, cycles since RUN/SET entry and since the last inc press.
    int m_mode, m_presc, m_hold, m_age;
    int m_ld [6];
    bit m_pm, m_pi;

    function automatic logic [28:0] outvec();
        return {sec_tick, load, mode, blink, ld_hour1, ld_hour0, ld_min1, ld_min0, ld_sec1, ld_sec0};
    endfunction

    task automatic check(input string name, input logic [28:0] act, input logic [28:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: actual=%h expected=%h", name, $time, act, exp);
        end
    endtask

    task automatic model_reset();
        m_mode = 0; m_presc = 0; m_hold = 0; m_age = 0; m_pm = 0; m_pi = 0;
        for (int i = 0; i < 6; i++) m_ld[i] = 0;
    endtask

    task automatic model_step(input bit bm, input bit bi);
        bit          pm, pi, chg, fire, e_tick, e_load, e_blink;
        int          f, v, mx;
        logic [28:0] e;
        logic [1:0]  mm;
        pm = bm && !m_pm;
        pi = bi && !m_pi;
        m_pm = bm; m_pi = bi;
        chg = 0; e_tick = 0; e_load = 0;
        if (m_mode == 0) begin
            if (pm) begin
                for (int i = 0; i < 6; i++) m_ld[i] = int'(cur_d[i]);
                m_mode = 1; chg = 1; m_presc = 0;
            end else begin
                m_presc = (m_presc + 1) % CLK_DIV;
                e_tick = (m_presc == 0);
            end
        end else begin
            m_presc = 0;
            if (pm) begin
                chg = 1;
                if (pi) m_mode = 0;
                else begin
                    e_load = (m_mode == 3);
                    m_mode = (m_mode + 1) % 4;
                end
            end else begin
                fire = 0;
                if (pi) begin
                    fire = 1; m_hold = 0;
                end else if (bi) begin
                    m_hold++;
                    fire = (m_hold == REPEAT_DLY) ||
                           (m_hold > REPEAT_DLY && (m_hold - REPEAT_DLY) % REPEAT_PER == 0);
                end else m_hold = 0;
                if (fire) begin
                    f  = 2 * (m_mode - 1);
                    mx = (m_mode == 1) ? 23 : 59;
                    v  = 10 * m_ld[f] + m_ld[f+1];
                    v  = (v >= mx) ? 0 : v + 1;
                    m_ld[f] = v / 10; m_ld[f+1] = v % 10;
                end
            end
        end
        if (chg) begin m_hold = 0; m_age = 0; end
        else if (m_mode != 0) m_age++;
        e_blink = (m_mode != 0) && ((m_age / BLINK_DIV) % 2 == 0);
        mm = m_mode[1:0];
        e = {e_tick, e_load, mm, e_blink, m_ld[0][3:0], m_ld[1][3:0], m_ld[2][3:0],
             m_ld[3][3:0], m_ld[4][3:0], m_ld[5][3:0]};
        exp_q.push_back(e);
    endtask

    task automatic cyc(input bit bm, input bit bi, input int n);
        for (int k = 0; k < n; k++) begin
            btn_mode = bm; btn_inc = bi;
            @(posedge clk);
            model_step(bm, bi);
            #2;
        end
    endtask

    task automatic set_cur(input int h1, input int h0, input int m1, input int m0,
                           input int s1, input int s0);
        cur_d[0] = 4'(h1); cur_d[1] = 4'(h0); cur_d[2] = 4'(m1);
        cur_d[3] = 4'(m0); cur_d[4] = 4'(s1); cur_d[5] = 4'(s0);
    endtask

    initial begin : monitor
        logic [28:0] e;
        forever begin
            @(posedge clk);
            #4;
            if (mon_en && exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("outputs", outvec(), e);
            end
        end
    end

    initial begin : stim
        bit rbm, rbi;
        set_cur(0, 0, 0, 0, 0, 0);
        model_reset();
        repeat (3) @(posedge clk);
        #2;
        check("reset_state", outvec(), '0);
        rst_n = 1'b1;
        mon_en = 1'b1;

        cyc(0, 0, 35);

        set_cur(2, 3, 5, 9, 5, 8);
        cyc(1, 0, 1); cyc(0, 0, 2);
        cyc(0, 1, 1); cyc(0, 0, 2);
        repeat (3) begin cyc(1, 0, 1); cyc(0, 0, 1); end
        cyc(0, 0, 12);

        set_cur(1, 2, 5, 8, 0, 0);
        repeat (2) begin cyc(1, 0, 1); cyc(0, 0, 1); end
        repeat (3) begin cyc(0, 1, 1); cyc(0, 0, 1); end
        cyc(1, 0, 1); cyc(0, 0, 1);
        cyc(0, 1, 40); cyc(0, 0, 5);
        cyc(1, 0, 1); cyc(0, 0, 3);

        cyc(1, 0, 1); cyc(0, 0, 2);
        cyc(1, 1, 1); cyc(0, 0, 12);

        set_cur(2, 7, 6, 4, 9, 9);
        repeat (2) begin cyc(1, 0, 1); cyc(0, 0, 1); end
        cyc(0, 1, 1); cyc(0, 0, 3);
        rst_n = 1'b0;
        #1;
        check("async_reset", outvec(), '0);
        mon_en = 1'b0;
        exp_q.delete();
        model_reset();
        btn_mode = 1'b0; btn_inc = 1'b0;
        repeat (2) @(posedge clk);
        #2;
        rst_n = 1'b1;
        mon_en = 1'b1;

        rbm = 0; rbi = 0;
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 9) == 0) rbm = ~rbm;
            if ($urandom_range(0, 39) == 0) rbi = ~rbi;
            if (!rbm && !rbi && $urandom_range(0, 59) == 0) begin rbm = 1; rbi = 1; end
            if ($urandom_range(0, 19) == 0)
                for (int d = 0; d < 6; d++) cur_d[d] = 4'($urandom_range(0, 9));
            cyc(rbm, rbi, 1);
        end
        cyc(0, 0, 2);
        #5;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
